cache_arbiter: RTL and testbench

- Shares one cache slave port among NREQ requester masters, e.g. instruction fetch and data load/store.
- Uses the cache's 4-phase request/valid handshake on both sides.
- Arbitration is round-robin, one transaction in flight at a time.
- A watchdog completes stalled transactions with an error flag so that no requester hangs.

---
 rtl/cache_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cache_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache port among NREQ requesters, one 4-phase transaction in flight.
// Latency: request->c_request 1 cycle, c_valid->m_valid 1 cycle; other requests stay pending, watchdog ends stalls.
module cache_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 8,
  parameter int AW      = 32,
  parameter int OPW     = 2,
  parameter int TIMEOUT = 255,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     m_request,
  input  logic [NREQ*OPW-1:0] m_op,
  input  logic [NREQ*AW-1:0]  m_addr,
  input  logic [NREQ*DW-1:0]  m_wdata,
  output logic [NREQ-1:0]     m_valid,
  output logic [NREQ-1:0]     m_evict,
  output logic [DW-1:0]       m_rdata,
  output logic                c_request,
  output logic [OPW-1:0]      c_op,
  output logic [AW-1:0]       c_addr,
  output logic [DW-1:0]       c_wdata,
  input  logic                c_valid,
  input  logic                c_evict,
  input  logic [DW-1:0]       c_rdata,
  output logic [IDW-1:0]      grant_id,
  output logic                timeout_err
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, REL} state_t;

  state_t          state, state_n;
  logic [IDW-1:0]  rr_ptr, rr_ptr_n;
  logic [WW-1:0]   wdog, wdog_n;
  logic [NREQ-1:0] m_valid_n, m_evict_n;
  logic [DW-1:0]   m_rdata_n, c_wdata_n;
  logic            c_request_n, timeout_err_n;
  logic [OPW-1:0]  c_op_n;
  logic [AW-1:0]   c_addr_n;
  logic [IDW-1:0]  grant_id_n;
  logic            win_vld;
  logic [IDW-1:0]  win;
  logic            timeout_hit;

  // Downward scan so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (m_request[(int'(rr_ptr) + k) % NREQ]) begin
        win_vld = 1'b1;
        win     = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wdog == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wdog        <= '0;
      m_valid     <= '0;
      m_evict     <= '0;
      m_rdata     <= '0;
      c_request   <= 1'b0;
      c_op        <= '0;
      c_addr      <= '0;
      c_wdata     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      wdog        <= wdog_n;
      m_valid     <= m_valid_n;
      m_evict     <= m_evict_n;
      m_rdata     <= m_rdata_n;
      c_request   <= c_request_n;
      c_op        <= c_op_n;
      c_addr      <= c_addr_n;
      c_wdata     <= c_wdata_n;
      grant_id    <= grant_id_n;
      timeout_err <= timeout_err_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (win_vld) state_n = REQ;
      REQ:  if (c_valid || timeout_hit) state_n = RESP;
      RESP: if (!m_request[grant_id]) state_n = REL;
      REL:  if (!c_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_n      = rr_ptr;
    wdog_n        = wdog;
    m_valid_n     = m_valid;
    m_evict_n     = m_evict;
    m_rdata_n     = m_rdata;
    c_request_n   = c_request;
    c_op_n        = c_op;
    c_addr_n      = c_addr;
    c_wdata_n     = c_wdata;
    grant_id_n    = grant_id;
    timeout_err_n = timeout_err;
    case (state)
      IDLE: begin
        if (win_vld) begin
          c_op_n      = m_op[int'(win) * OPW +: OPW];
          c_addr_n    = m_addr[int'(win) * AW +: AW];
          c_wdata_n   = m_wdata[int'(win) * DW +: DW];
          grant_id_n  = win;
          c_request_n = 1'b1;
          wdog_n      = '0;
        end
      end
      REQ: begin
        wdog_n = wdog + 1'b1;
        if (c_valid) begin
          m_rdata_n           = c_rdata;
          m_evict_n           = '0;
          m_evict_n[grant_id] = c_evict;
          m_valid_n           = '0;
          m_valid_n[grant_id] = 1'b1;
        end else if (timeout_hit) begin
          timeout_err_n       = 1'b1;
          m_rdata_n           = '0;
          m_evict_n           = '0;
          m_valid_n           = '0;
          m_valid_n[grant_id] = 1'b1;
        end
      end
      RESP: begin
        if (!m_request[grant_id]) begin
          m_valid_n   = '0;
          m_evict_n   = '0;
          c_request_n = 1'b0;
        end
      end
      REL: begin
        // A late c_valid (e.g. after a timeout) is held off here until it falls.
        if (!c_valid) begin
          if (grant_id == IDW'(NREQ - 1)) rr_ptr_n = '0;
          else                            rr_ptr_n = grant_id + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a watchdog of 4 cycles and a hand-driven cache.
module tb_cache_arbiter;

  localparam int NREQ = 2, DW = 8, AW = 32, OPW = 2, TIMEOUT = 4;

  logic                clock, reset;
  logic [NREQ-1:0]     m_request;
  logic [NREQ*OPW-1:0] m_op;
  logic [NREQ*AW-1:0]  m_addr;
  logic [NREQ*DW-1:0]  m_wdata;
  logic [NREQ-1:0]     m_valid, m_evict;
  logic [DW-1:0]       m_rdata;
  logic                c_request;
  logic [OPW-1:0]      c_op;
  logic [AW-1:0]       c_addr;
  logic [DW-1:0]       c_wdata;
  logic                c_valid, c_evict;
  logic [DW-1:0]       c_rdata;
  logic [0:0]          grant_id;
  logic                timeout_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  cache_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .m_request(m_request), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_valid(m_valid), .m_evict(m_evict), .m_rdata(m_rdata),
    .c_request(c_request), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_valid(c_valid), .c_evict(c_evict), .c_rdata(c_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_creq"}, 32'(c_request), 0);
    check({tag, "_mvld"}, 32'(m_valid), 0);
    check({tag, "_mrd"},  32'(m_rdata), 0);
    check({tag, "_addr"}, c_addr, 0);
    check({tag, "_op"},   32'(c_op), 0);
    check({tag, "_gid"},  32'(grant_id), 0);
    check({tag, "_terr"}, 32'(timeout_err), 0);
  endtask

  // Wait for the grant to requester g, answer after 3 REQ edges, then run the release handshake.
  task automatic serve(input int g, input logic [DW-1:0] rd, input logic ev);
    logic [31:0] exp_addr;
    exp_addr = (g == 0) ? 32'h1000 : 32'h2000;
    for (int i = 0; i < 20 && c_request !== 1'b1; i++) tick();
    check("serve_creq", 32'(c_request), 1);
    check("serve_gid", 32'(grant_id), g);
    check("serve_addr", c_addr, exp_addr);
    tick();
    tick();
    check("serve_novld", 32'(m_valid), 0);
    c_valid = 1'b1; c_rdata = rd; c_evict = ev;
    tick();
    check("serve_vld", 32'(m_valid), 1 << g);
    check("serve_rdata", 32'(m_rdata), 32'(rd));
    check("serve_evict", 32'(m_evict), 32'(ev) << g);
    m_request[g] = 1'b0;
    tick();
    check("serve_drop_creq", 32'(c_request), 0);
    check("serve_drop_vld", 32'(m_valid), 0);
    c_valid = 1'b0; c_evict = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    m_request = '0; c_valid = 1'b0; c_evict = 1'b0; c_rdata = '0;
    m_addr  = {32'h2000, 32'h1000};
    m_op    = {2'd1, 2'd0};
    m_wdata = {8'h77, 8'h11};
    tick(); tick();
    check_all_zero("reset");
    @(negedge clock) reset = 1'b1;
    tick();

    // c_valid while idle must not produce a completion
    c_valid = 1'b1; c_rdata = 8'hFF;
    tick(); tick();
    check("idle_cvalid_vld", 32'(m_valid), 0);
    check("idle_cvalid_rd", 32'(m_rdata), 0);
    c_valid = 1'b0;
    tick();

    // Single read from requester 0
    m_request = 2'b01;
    check("t1_pre_creq", 32'(c_request), 0);
    tick();
    check("t1_creq", 32'(c_request), 1);
    check("t1_op", 32'(c_op), 0);
    serve(0, 8'hA5, 1'b0);

    // Simultaneous requests from reset: 0,1,0,1
    reset = 1'b0;
    #2;
    reset = 1'b1;
    m_request = 2'b11;
    serve(0, 8'h11, 1'b0);
    m_request[0] = 1'b1;
    serve(1, 8'h22, 1'b0);
    m_request[1] = 1'b1;
    serve(0, 8'h33, 1'b0);
    serve(1, 8'h44, 1'b0);

    // Evict on a requester 1 write
    m_request = 2'b10;
    tick();
    check("ev_op", 32'(c_op), 1);
    check("ev_wdata", 32'(c_wdata), 32'h77);
    serve(1, 8'h3C, 1'b1);

    // Watchdog: cache stays silent
    m_request = 2'b01;
    tick();
    check("wd_creq", 32'(c_request), 1);
    tick(); tick(); tick();
    check("wd_early_vld", 32'(m_valid), 0);
    check("wd_early_err", 32'(timeout_err), 0);
    tick();
    check("wd_vld", 32'(m_valid), 1);
    check("wd_rdata", 32'(m_rdata), 0);
    check("wd_evict", 32'(m_evict), 0);
    check("wd_err", 32'(timeout_err), 1);
    m_request = 2'b00;
    tick();
    check("wd_drop_creq", 32'(c_request), 0);
    check("wd_drop_vld", 32'(m_valid), 0);
    c_valid = 1'b1;
    m_request = 2'b10;
    tick(); tick();
    check("wd_absorb_creq", 32'(c_request), 0);
    c_valid = 1'b0;
    serve(1, 8'h5A, 1'b0);
    check("wd_sticky", 32'(timeout_err), 1);

    // Reset while in RESP
    m_request = 2'b01;
    tick();
    check("rst_creq", 32'(c_request), 1);
    tick(); tick();
    c_valid = 1'b1; c_rdata = 8'h99;
    tick();
    check("rst_resp_vld", 32'(m_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    c_valid = 1'b0;
    m_request = 2'b10;
    @(negedge clock) reset = 1'b1;
    tick();
    check("rst_after_creq", 32'(c_request), 1);
    check("rst_after_gid", 32'(grant_id), 1);
    serve(1, 8'h66, 1'b0);

    // Early request drop by requester 0
    m_request = 2'b01;
    tick();
    m_request = 2'b00;
    check("ed_creq", 32'(c_request), 1);
    tick(); tick();
    c_valid = 1'b1; c_rdata = 8'h81;
    tick();
    check("ed_vld", 32'(m_valid), 1);
    check("ed_rdata", 32'(m_rdata), 32'h81);
    tick();
    check("ed_vld_gone", 32'(m_valid), 0);
    check("ed_creq_gone", 32'(c_request), 0);
    c_valid = 1'b0;
    tick();
    m_request = 2'b10;
    tick();
    check("ed_next_creq", 32'(c_request), 1);
    check("ed_next_gid", 32'(grant_id), 1);
    serve(1, 8'h42, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
